// File: rtl/dsp_mac_ctrl_if.sv
// Command / operand / result handshake bundle for dsp_mac_ctrl.
// cmd_sub exists only when DSP_MAC_CTRL_SUB_EN is defined.
interface dsp_mac_ctrl_if #(
    parameter int WIDTH = 18,
    parameter int CNT_W = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [CNT_W-1:0]        cmd_len;
`ifdef DSP_MAC_CTRL_SUB_EN
    logic                    cmd_sub;
`endif
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_a;
    logic signed [WIDTH-1:0] in_b;
    logic                    res_valid;
    logic                    res_ready;

`ifdef DSP_MAC_CTRL_SUB_EN
    modport master (
        output cmd_valid, cmd_len, cmd_sub, in_valid, in_a, in_b, res_ready,
        input  cmd_ready, in_ready, res_valid
    );
    modport slave (
        input  cmd_valid, cmd_len, cmd_sub, in_valid, in_a, in_b, res_ready,
        output cmd_ready, in_ready, res_valid
    );
`else
    modport master (
        output cmd_valid, cmd_len, in_valid, in_a, in_b, res_ready,
        input  cmd_ready, in_ready, res_valid
    );
    modport slave (
        input  cmd_valid, cmd_len, in_valid, in_a, in_b, res_ready,
        output cmd_ready, in_ready, res_valid
    );
`endif
endinterface

// File: rtl/dsp_mac_ctrl.sv
// Sequencer driving one DSP48A1 slice as a multiply-accumulator (A/B, M, P regs on).
// Define DSP_MAC_CTRL_SUB_EN to add cmd_sub, which negates the accumulated result.
module dsp_mac_ctrl #(
    parameter int WIDTH     = 18,
    parameter int CNT_W     = 8,
    parameter int OPMODEREG = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dsp_mac_ctrl_if.slave           bus,
    output logic signed [WIDTH-1:0] a_out,
    output logic signed [WIDTH-1:0] b_out,
    output logic                    ce_ab,
    output logic                    ce_m,
    output logic                    ce_p,
    output logic                    ce_opm,
    output logic [7:0]              opmode
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_P    = 2'b10;

    logic [1:0]       state;
    logic [CNT_W-1:0] rem;
    logic             accept;
    logic             issue;
    logic             first_p0;
    logic             vld_p1;
    logic             first_p1;
    logic             vld_p2;
    logic             sub_q;
    logic             opm_load;
    logic             opm_first;

    // First product loads P from M alone; later products add M onto P.
    function automatic logic [7:0] opmode_word(input logic first, input logic sub);
        opmode_word = {sub, 3'b000, (first ? Z_ZERO : Z_P), X_M};
    endfunction

    assign bus.cmd_ready = (state == S_IDLE) && rst_n;
    assign bus.in_ready  = (state == S_RUN);
    assign bus.res_valid = (state == S_DONE);

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign issue  = bus.in_valid && bus.in_ready;

    assign a_out = bus.in_a;
    assign b_out = bus.in_b;

    // Stage p0: operand issue into the slice A/B registers
    assign ce_ab = issue;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rem      <= '0;
            first_p0 <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && (bus.cmd_len != '0)) begin
                        rem      <= bus.cmd_len;
                        first_p0 <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        rem      <= rem - CNT_W'(1);
                        first_p0 <= 1'b0;
                        if (rem == CNT_W'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                // Issue is impossible here, so an empty p1 means p2 empties at this edge.
                S_DRAIN: begin
                    if (!vld_p1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DSP_MAC_CTRL_SUB_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= bus.cmd_sub;
        end
    end
`else
    assign sub_q = 1'b0;
`endif

    // Stage p1 / p2: tokens shadow the slice M and P registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            vld_p1   <= issue;
            first_p1 <= issue && first_p0;
            vld_p2   <= vld_p1;
        end
    end

    assign ce_m = vld_p1;
    assign ce_p = vld_p2;

    // Unregistered slice OPMODE must be valid in the P cycle; registered needs it one cycle earlier.
    assign opm_load  = (OPMODEREG != 0) ? issue    : vld_p1;
    assign opm_first = (OPMODEREG != 0) ? first_p0 : first_p1;
    assign ce_opm    = (OPMODEREG != 0) ? vld_p1   : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opmode <= 8'h00;
        end else if (opm_load) begin
            opmode <= opmode_word(opm_first, sub_q);
        end
    end
endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Bench for dsp_mac_ctrl: two instances (OPMODEREG 0 and 1) each feeding a DSP48A1 MAC model.
// Vectors come from a table; CE timing, opmode and P results are scoreboarded through queues.
module tb_dsp_mac_ctrl;
    localparam int W  = 18;
    localparam int CW = 8;
`ifdef DSP_MAC_CTRL_SUB_EN
    localparam bit SUB1 = 1'b1;
`else
    localparam bit SUB1 = 1'b0;
`endif

    logic clk;
    logic rst_n;

    dsp_mac_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus0 ();
    dsp_mac_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus1 ();

    logic signed [W-1:0] a_out0, b_out0, a_out1, b_out1;
    logic                ce_ab0, ce_m0, ce_p0, ce_opm0;
    logic                ce_ab1, ce_m1, ce_p1, ce_opm1;
    logic [7:0]          opmode0, opmode1;

    dsp_mac_ctrl #(.WIDTH(W), .CNT_W(CW), .OPMODEREG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .a_out(a_out0), .b_out(b_out0),
        .ce_ab(ce_ab0), .ce_m(ce_m0), .ce_p(ce_p0), .ce_opm(ce_opm0),
        .opmode(opmode0)
    );

    dsp_mac_ctrl #(.WIDTH(W), .CNT_W(CW), .OPMODEREG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .a_out(a_out1), .b_out(b_out1),
        .ce_ab(ce_ab1), .ce_m(ce_m1), .ce_p(ce_p1), .ce_opm(ce_opm1),
        .opmode(opmode1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DSP48A1 post-adder: P = Z +/- X, with opmode[7] selecting subtraction.
    function automatic logic signed [47:0] slice_post(input logic [7:0] op,
                                                       input logic signed [47:0] p,
                                                       input logic signed [35:0] m);
        logic signed [47:0] z;
        logic signed [47:0] x;
        z = (op[3:2] == 2'b10) ? p : 48'sd0;
        x = 48'sd0;
        if (op[1:0] == 2'b01) x = m;
        slice_post = op[7] ? (z - x) : (z + x);
    endfunction

    logic signed [W-1:0] a0_r, b0_r, a1_r, b1_r;
    logic signed [35:0]  m0_r, m1_r;
    logic signed [47:0]  p0_r, p1_r;
    logic [7:0]          opm1_r;

    always @(posedge clk) begin
        if (ce_ab0) begin a0_r <= a_out0; b0_r <= b_out0; end
        if (ce_m0)  m0_r <= a0_r * b0_r;
        if (ce_p0)  p0_r <= slice_post(opmode0, p0_r, m0_r);
        if (ce_ab1) begin a1_r <= a_out1; b1_r <= b_out1; end
        if (ce_m1)  m1_r <= a1_r * b1_r;
        if (ce_opm1) opm1_r <= opmode1;
        if (ce_p1)  p1_r <= slice_post(opm1_r, p1_r, m1_r);
    end

    typedef struct {
        int     len;
        int     base;
        int     stall_before;
        int     stall_n;
        int     hold;
        longint exp_sum;
    } vec_t;

    vec_t tbl[6];
    int   opa[12];
    int   opb[12];

    int checks = 0;
    int errors = 0;

    int         cmq0[$];
    int         cpq0[$];
    logic [7:0] opq0[$];
    longint     sumq0[$];
    logic [7:0] opq1[$];
    longint     sumq1[$];
    int  n_ab0 = 0, n_m0 = 0, n_p0 = 0, n_opm1 = 0;
    bit  rs0 = 1'b0, rs1 = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon();
        if (ce_ab0) n_ab0++;
        if (ce_m0) begin
            n_m0++;
            if (cmq0.size() == 0) chk("ce_m0_spurious", 1, 0);
            else chk("ce_m0_cycle", cyc, cmq0.pop_front());
        end
        if (ce_p0) begin
            n_p0++;
            if (cpq0.size() == 0 || opq0.size() == 0) chk("ce_p0_spurious", 1, 0);
            else begin
                chk("ce_p0_cycle", cyc, cpq0.pop_front());
                chk("opmode0", opmode0, opq0.pop_front());
            end
        end
        if (bus0.res_valid && !rs0) begin
            if (sumq0.size() == 0) chk("res0_spurious", 1, 0);
            else chk("p0_result", p0_r, sumq0.pop_front());
        end
        rs0 = bus0.res_valid;
        if (ce_opm1 || ce_m1) chk("ce_opm1_align", ce_opm1, ce_m1);
        if (ce_opm1) begin
            n_opm1++;
            if (opq1.size() == 0) chk("ce_opm1_spurious", 1, 0);
            else chk("opmode1", opmode1, opq1.pop_front());
        end
        if (bus1.res_valid && !rs1) begin
            if (sumq1.size() == 0) chk("res1_spurious", 1, 0);
            else chk("p1_result", p1_r, sumq1.pop_front());
        end
        rs1 = bus1.res_valid;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        int   t0, k, st, nab, nm, np, rc;
        bit   got;
        v   = tbl[vi];
        nab = n_ab0; nm = n_m0; np = n_p0;
        chk("cmd_ready_idle", bus0.cmd_ready, 1);
        bus0.cmd_valid = 1'b1;
        bus0.cmd_len   = CW'(v.len);
        sumq0.push_back(v.exp_sum);
        t0 = cyc;
        tick();
        bus0.cmd_valid = 1'b0;
        #1;
        chk("in_ready_run", bus0.in_ready, 1);
        k = 0; st = 0;
        while (k < v.len) begin
            if (k == v.stall_before && st < v.stall_n) begin
                bus0.in_valid = 1'b0;
                st++;
                #1;
                chk("ce_ab_stall", ce_ab0, 0);
            end else begin
                bus0.in_valid = 1'b1;
                bus0.in_a = W'(opa[v.base + k]);
                bus0.in_b = W'(opb[v.base + k]);
                cmq0.push_back(cyc + 1);
                cpq0.push_back(cyc + 2);
                opq0.push_back((k == 0) ? 8'h01 : 8'h09);
                k++;
            end
            tick();
        end
        bus0.in_valid = 1'b0;
        #1;
        chk("in_ready_drain", bus0.in_ready, 0);
        got = 1'b0; rc = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus0.res_valid) begin got = 1'b1; rc = cyc; break; end
            tick();
            #1;
        end
        chk("res_valid_seen", got, 1);
        chk("res_cycle", rc, t0 + v.len + v.stall_n + 3);
        for (int h = 0; h < v.hold; h++) begin
            chk("res_hold_valid", bus0.res_valid, 1);
            chk("res_hold_cmd_ready", bus0.cmd_ready, 0);
            tick();
            #1;
        end
        bus0.res_ready = 1'b1;
        chk("res_valid_at_ready", bus0.res_valid, 1);
        tick();
        bus0.res_ready = 1'b0;
        #1;
        chk("idle_after_res_valid", bus0.res_valid, 0);
        chk("idle_after_res_cmd_ready", bus0.cmd_ready, 1);
        chk("ce_ab_count", n_ab0 - nab, v.len);
        chk("ce_m_count", n_m0 - nm, v.len);
        chk("ce_p_count", n_p0 - np, v.len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  t0, nab, np;
        bit  got;
        opa = '{2, 4, 1, -5, 100, -2, 131071, -131072, -1, 0, 7, 0};
        opb = '{3, 5, 1, 7, -3, -2, 131071, -131072, 1, 9, 7, 0};
        tbl[0] = '{3, 0, -1, 0, 0, 64'sd27};
        tbl[1] = '{3, 0,  1, 2, 0, 64'sd27};
        tbl[2] = '{4, 3, -1, 0, 1, 64'sd17179606710};
        tbl[3] = '{1, 7, -1, 0, 5, 64'sd17179869184};
        tbl[4] = '{2, 8,  0, 1, 0, -64'sd1};
        tbl[5] = '{1, 10, -1, 0, 0, 64'sd49};

        rst_n = 1'b0;
        bus0.cmd_valid = 1'b0; bus0.cmd_len = '0; bus0.in_valid = 1'b0;
        bus0.in_a = '0; bus0.in_b = '0; bus0.res_ready = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_len = '0; bus1.in_valid = 1'b0;
        bus1.in_a = '0; bus1.in_b = '0; bus1.res_ready = 1'b0;
`ifdef DSP_MAC_CTRL_SUB_EN
        bus0.cmd_sub = 1'b0;
        bus1.cmd_sub = 1'b1;
`endif
        tick();
        tick();
        #1;
        chk("rst_cmd_ready", bus0.cmd_ready, 0);
        chk("rst_in_ready", bus0.in_ready, 0);
        chk("rst_res_valid", bus0.res_valid, 0);
        chk("rst_ce_p", ce_p0, 0);
        chk("rst_opmode0", opmode0, 0);
        chk("rst_ce_opm1", ce_opm1, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready0", bus0.cmd_ready, 1);
        chk("post_rst_cmd_ready1", bus1.cmd_ready, 1);

        for (int i = 0; i < 5; i++) run_vec(i);

        // cmd_len = 0 is swallowed in IDLE; in_valid is held high to expose any stray issue
        nab = n_ab0; np = n_p0;
        chk("len0_cmd_ready", bus0.cmd_ready, 1);
        bus0.cmd_valid = 1'b1;
        bus0.cmd_len   = '0;
        bus0.in_valid  = 1'b1;
        tick();
        bus0.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("len0_cmd_ready_hold", bus0.cmd_ready, 1);
            chk("len0_in_ready", bus0.in_ready, 0);
            chk("len0_res_valid", bus0.res_valid, 0);
            tick();
        end
        bus0.in_valid = 1'b0;
        chk("len0_ce_ab_none", n_ab0 - nab, 0);
        chk("len0_ce_p_none", n_p0 - np, 0);

        // Reset in cycle t_2+1 of a 4-product command
        #1;
        bus0.cmd_valid = 1'b1;
        bus0.cmd_len   = CW'(4);
        t0 = cyc;
        tick();
        bus0.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus0.in_valid = 1'b1;
            bus0.in_a = W'(k + 1);
            bus0.in_b = W'(2);
            cmq0.push_back(cyc + 1);
            cpq0.push_back(cyc + 2);
            opq0.push_back((k == 0) ? 8'h01 : 8'h09);
            tick();
        end
        bus0.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_cycle", cyc, t0 + 4);
        chk("midrst_cmd_ready_low", bus0.cmd_ready, 0);
        tick();
        rst_n = 1'b1;
        cmq0.delete();
        cpq0.delete();
        opq0.delete();
        #1;
        chk("midrst_in_ready", bus0.in_ready, 0);
        chk("midrst_ce_ab", ce_ab0, 0);
        chk("midrst_ce_m", ce_m0, 0);
        chk("midrst_ce_p", ce_p0, 0);
        chk("midrst_ce_opm", ce_opm0, 0);
        chk("midrst_res_valid", bus0.res_valid, 0);
        chk("midrst_opmode", opmode0, 0);
        chk("midrst_cmd_ready", bus0.cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_result", bus0.res_valid, 0);
            tick();
            #1;
        end
        run_vec(5);

        // Registered-OPMODE instance: ce_opm aligned with ce_m, subtract when enabled
        chk("dut1_cmd_ready", bus1.cmd_ready, 1);
        bus1.cmd_valid = 1'b1;
        bus1.cmd_len   = CW'(2);
        sumq1.push_back(SUB1 ? -64'sd11 : 64'sd11);
        tick();
        bus1.cmd_valid = 1'b0;
        bus1.in_valid  = 1'b1;
        bus1.in_a = W'(3); bus1.in_b = W'(3);
        opq1.push_back(SUB1 ? 8'h81 : 8'h01);
        tick();
        bus1.in_a = W'(1); bus1.in_b = W'(2);
        opq1.push_back(SUB1 ? 8'h89 : 8'h09);
        tick();
        bus1.in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus1.res_valid) begin got = 1'b1; break; end
            tick();
        end
        chk("dut1_res_valid_seen", got, 1);
        tick();
        bus1.res_ready = 1'b1;
        tick();
        bus1.res_ready = 1'b0;
        #1;
        chk("dut1_idle_cmd_ready", bus1.cmd_ready, 1);
        chk("dut1_ce_opm_count", n_opm1, 2);

        tick();
        chk("scoreboard_drained",
            cmq0.size() + cpq0.size() + opq0.size() + sumq0.size() + opq1.size() + sumq1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dsp_mac_ctrl.md
# dsp_mac_ctrl

Sequencer for one DSP48A1 slice running as a multiply-accumulator with its A/B input, M and P registers enabled. Accepts a command giving a product count, streams operand pairs into the slice under valid/ready, drives OPMODE and the per-stage clock enables so the first product loads P and later products accumulate, and raises a result handshake once the final sum is in P. The slice's stage registers see CE only when a valid product occupies them, so input stalls leave bubbles that never disturb P.

## Interface
- WIDTH, 18: operand width of in_a/in_b and a_out/b_out.
- CNT_W, 8: width of cmd_len and the internal remaining-count register.
- OPMODEREG, 0: 0 means the slice's OPMODE is unregistered. 1 means it is registered and enabled by ce_opm.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE, and only while rst_n=1.
- cmd_len  in  CNT_W  number of products N.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  high only in RUN.
- in_a, in_b  in  WIDTH  operands.
- a_out, b_out  out  WIDTH  to slice A/B. Combinational pass-through of in_a/in_b.
- ce_ab  out  1  slice A/B register CE.
- ce_m  out  1  slice M register CE.
- ce_p  out  1  slice P register CE.
- ce_opm  out  1  slice OPMODE register CE. Held 0 when OPMODEREG=0.
- opmode  out  8  slice OPMODE.
- res_valid  out  1  P holds the final sum.
- res_ready  in  1  result consumed.

## Operation
- States:
  - IDLE: cmd_ready=1. On cmd_valid with cmd_len≠0, latch N into rem and go to RUN. cmd_len=0 is accepted and dropped; the block stays in IDLE and produces no result.
  - RUN: in_ready=1. issue = in_valid & in_ready; ce_ab = issue (combinational). Each issue decrements rem. The issue that makes rem reach 0 moves the block to DRAIN.
  - DRAIN: in_ready=0. Wait until the token pipeline is empty, then go to DONE.
  - DONE: res_valid=1. On res_ready, go to IDLE.
- Token pipeline: registered tok1 <= issue, tok2 <= tok1. ce_m = tok1, ce_p = tok2.
- Each token carries a first flag, set on the first issue of a command.
- opmode bit fields:
  - X field [1:0] = 01 (M).
  - Z field [3:2] = 00 when the first flag is set, 10 (P) otherwise.
  - Bits [7:4] = 0.
  - First product: 8'h01. Subsequent products: 8'h09.
- opmode alignment:
  - OPMODEREG=0: opmode is registered from tok1's flag, so it is valid in the tok2 cycle.
  - OPMODEREG=1: opmode is valid in the tok1 cycle, with ce_opm = tok1.
  - Between tokens, opmode holds its last value.
- Reset (rst_n=0 at an edge): state becomes IDLE, rem=0, tok1=tok2=0, first flags cleared, opmode=8'h00, ce_opm=0. This applies from any state, including mid-RUN, DRAIN or DONE. Any in-flight sum is abandoned with no res_valid.
- res_ready has no effect outside DONE. cmd_valid has no effect outside IDLE.

## Timing
- Command accepted at edge T; RUN from cycle T+1.
- Product k issued in cycle t_k: ce_ab at t_k, ce_m at t_k+1, ce_p at t_k+2.
- Last issue in cycle t_L: state is DRAIN from t_L+1; res_valid rises in cycle t_L+3.
- With no stalls, an N-product command accepted at T issues in T+1..T+N and gives res_valid at T+N+3.
- A stall cycle (in_valid=0 in RUN) produces no CE pulse at any stage.
- After the result handshake there is at least one IDLE cycle before the next command is accepted.
- Reset values:
  - cmd_ready=0 while rst_n=0, then 1.
  - in_ready, ce_m, ce_p, ce_opm, res_valid = 0.
  - ce_ab = 0 (in_ready is 0).
  - opmode = 8'h00.

## Configuration
- DSP_MAC_CTRL_SUB_EN defined:
  - Adds input port cmd_sub (1 bit), latched at command accept.
  - When cmd_sub is latched 1, opmode[7]=1 on every product, so the result is −Σ(a·b). First product 8'h81, subsequent 8'h89.
- Not defined: cmd_sub is absent and opmode[7] is constant 0.

## Test plan
- Reset, then cmd_len=3 with pairs (2,3),(4,5),(1,1) streamed without stalls. Required: opmode 01,09,09 in the ce_p cycles; ce_p pulses in T+3..T+5; res_valid at T+6. With a slice model, P=27.
- Same command with in_valid low for 2 cycles between products 1 and 2. Required: exactly 3 pulses each of ce_ab, ce_m and ce_p; no CE pulse during the stall cycles; P=27; res_valid delayed by 2 cycles.
- cmd_len=0. Required: accepted in one cycle, no CE or in_ready activity, res_valid stays 0, cmd_ready stays 1.
- Reset pulse in cycle t_2+1 of a 4-product command. Required: all outputs at reset values the next cycle, no res_valid. A new cmd_len=1 with (7,7) then gives P=49.
- res_ready held low for 5 cycles in DONE. Required: res_valid stays 1 and cmd_ready stays 0 throughout; on res_ready, IDLE the next cycle.
- OPMODEREG=1, with DSP_MAC_CTRL_SUB_EN defined and cmd_sub=1, cmd_len=2, pairs (3,3),(1,2). Required: ce_opm aligned with ce_m; opmode 81 then 89; P=−11.
